// File: rtl/truth_table_sweeper_if.sv
// Handshake/result bundle between the sweeper and its user.
// The master side drives start/expected and returns the function output f_in.
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    localparam int NV = 1 << N_IN;

    logic            start;
    logic [NV-1:0]   expected;
    logic [N_IN-1:0] x;
    logic            f_in;
    logic            busy;
    logic            done;
    logic [NV-1:0]   table_out;
    logic [N_IN:0]   mismatch_count;
    logic            fail_valid;
    logic [N_IN-1:0] first_fail;

    modport master (
        output start, expected, f_in,
        input  x, busy, done, table_out, mismatch_count, fail_valid, first_fail
    );

    modport slave (
        input  start, expected, f_in,
        output x, busy, done, table_out, mismatch_count, fail_valid, first_fail
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives all 2^N_IN vectors, samples f_in after SETTLE cycles,
// and compares against an expected mask. Define SWEEP_GRAY_EN for Gray-code application order.
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    truth_table_sweeper_if.slave sw
);
    localparam int NV = 1 << N_IN;
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

    state_t          state_q, state_d;
    logic [N_IN:0]   idx_q, idx_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [NV-1:0]   table_q, table_d;
    logic [N_IN:0]   mm_q, mm_d;
    logic            fail_q, fail_d;
    logic [N_IN-1:0] first_q, first_d;

    logic [N_IN-1:0] vec;
    logic            last_wait;
    logic            last_vec;
    logic            miss;

`ifdef SWEEP_GRAY_EN
    assign vec = idx_q[N_IN-1:0] ^ (idx_q[N_IN-1:0] >> 1);
`else
    assign vec = idx_q[N_IN-1:0];
`endif

    assign last_wait = (wait_q == WW'(SETTLE - 1));
    assign last_vec  = (idx_q == (N_IN+1)'(NV - 1));
    assign miss      = (sw.f_in != sw.expected[vec]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            table_q <= '0;
            mm_q    <= '0;
            fail_q  <= 1'b0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            table_q <= table_d;
            mm_q    <= mm_d;
            fail_q  <= fail_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sw.start) state_d = DRIVE;
            DRIVE:   if (last_wait) state_d = SAMPLE;
            SAMPLE:  state_d = last_vec ? FINISH : DRIVE;
            default: state_d = IDLE;
        endcase
    end

    // Results are only touched on an accepted start or in SAMPLE, so they hold after done.
    always_comb begin
        idx_d   = idx_q;
        wait_d  = wait_q;
        table_d = table_q;
        mm_d    = mm_q;
        fail_d  = fail_q;
        first_d = first_q;
        case (state_q)
            IDLE: begin
                if (sw.start) begin
                    idx_d   = '0;
                    wait_d  = '0;
                    table_d = '0;
                    mm_d    = '0;
                    fail_d  = 1'b0;
                    first_d = '0;
                end
            end
            DRIVE: wait_d = last_wait ? '0 : wait_q + 1'b1;
            SAMPLE: begin
                table_d[vec] = sw.f_in;
                if (miss) begin
                    mm_d = mm_q + 1'b1;
                    if (!fail_q) begin
                        fail_d  = 1'b1;
                        first_d = vec;
                    end
                end
                if (!last_vec) idx_d = idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        sw.busy           = (state_q == DRIVE) || (state_q == SAMPLE);
        sw.done           = (state_q == FINISH);
        sw.x              = sw.busy ? vec : '0;
        sw.table_out      = table_q;
        sw.mismatch_count = mm_q;
        sw.fail_valid     = fail_q;
        sw.first_fail     = first_q;
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper (N_IN=4, SETTLE=1) against a table-level model.
module tb_truth_table_sweeper;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] func = 16'hFCCC;
    int          total = 0;
    int          bad = 0;
    int          done_pulses = 0;
    logic        busy_prev = 1'b0;
    logic [3:0]  xs[$];

    truth_table_sweeper_if #(.N_IN(4)) sif ();

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut (
        .clk(clk),
        .rst(rst),
        .sw (sif)
    );

    always #5 clk = ~clk;

    // Stand-in combinational block: its truth table is simply the func mask.
    always_comb sif.f_in = func[sif.x];

    // Records the distinct applied vectors of the current sweep and counts done pulses.
    always @(negedge clk) begin
        if (sif.done) done_pulses++;
        if (sif.busy && !busy_prev) xs.delete();
        if (sif.busy && (xs.size() == 0 || xs[$] != sif.x)) xs.push_back(sif.x);
        busy_prev = sif.busy;
    end

    function automatic logic [3:0] vec_of(input int i);
`ifdef SWEEP_GRAY_EN
        return 4'(i ^ (i >> 1));
`else
        return 4'(i);
`endif
    endfunction

    function automatic logic [3:0] model_first(input logic [15:0] f, input logic [15:0] e);
        for (int i = 0; i < 16; i++)
            if (f[vec_of(i)] != e[vec_of(i)]) return vec_of(i);
        return 4'd0;
    endfunction

    // Starts a sweep (start sampled at edge 1); extra start pulses land on edges s1/s2.
    task automatic do_sweep(input logic [15:0] e, input int s1, input int s2,
                            output int done_edge, output int pulses);
        int edges;
        int n0;
        n0 = done_pulses;
        done_edge = -1;
        @(negedge clk);
        sif.expected = e;
        sif.start = 1'b1;
        @(posedge clk);
        edges = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sif.done) begin
                done_edge = edges;
                break;
            end
            sif.start = (edges + 1 == s1) || (edges + 1 == s2);
            @(posedge clk);
            edges++;
        end
        sif.start = 1'b0;
        repeat (3) @(negedge clk);
        pulses = done_pulses - n0;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.x !== 4'd0) begin
            bad++;
            $display("FAIL reset_ctrl got busy=%b done=%b x=%h want 0 0 0", sif.busy, sif.done, sif.x);
        end
        total++;
        if ({sif.table_out, sif.mismatch_count, sif.fail_valid, sif.first_fail} !== 26'd0) begin
            bad++;
            $display("FAIL reset_results got table=%h mm=%0d fv=%b ff=%h want all 0",
                     sif.table_out, sif.mismatch_count, sif.fail_valid, sif.first_fail);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_match;
        int de, np;
        func = 16'hFCCC;
        do_sweep(16'hFCCC, -1, -1, de, np);
        total++;
        if (de !== 33) begin bad++; $display("FAIL match_latency got=%0d want=33", de); end
        total++;
        if (np !== 1) begin bad++; $display("FAIL match_pulses got=%0d want=1", np); end
        total++;
        if (sif.table_out !== 16'hFCCC) begin
            bad++; $display("FAIL match_table got=%h want=fccc", sif.table_out);
        end
        total++;
        if (sif.mismatch_count !== 5'd0 || sif.fail_valid !== 1'b0) begin
            bad++; $display("FAIL match_counts got mm=%0d fv=%b want 0 0", sif.mismatch_count, sif.fail_valid);
        end
        total++;
        if (sif.busy !== 1'b0) begin bad++; $display("FAIL match_busy_after got=%b want=0", sif.busy); end
        total++;
        if (xs.size() != 16) begin
            bad++; $display("FAIL seq_len got=%0d want=16", xs.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (xs[i] !== vec_of(i)) begin
                    bad++; $display("FAIL seq_vec[%0d] got=%h want=%h", i, xs[i], vec_of(i));
                end
`ifdef SWEEP_GRAY_EN
                if (i > 0) begin
                    total++;
                    if ($countones(xs[i] ^ xs[i-1]) != 1) begin
                        bad++; $display("FAIL seq_hamming[%0d] got=%0d want=1", i, $countones(xs[i] ^ xs[i-1]));
                    end
                end
`endif
            end
        end
    endtask

    task automatic test_single_fault;
        int de, np;
        func = 16'hFCCC;
        do_sweep(16'hFCEC, -1, -1, de, np);
        total++;
        if (sif.mismatch_count !== 5'd1 || sif.fail_valid !== 1'b1) begin
            bad++; $display("FAIL single_counts got mm=%0d fv=%b want 1 1", sif.mismatch_count, sif.fail_valid);
        end
        total++;
        if (sif.first_fail !== 4'd5) begin bad++; $display("FAIL single_first got=%0d want=5", sif.first_fail); end
        total++;
        if (sif.table_out !== 16'hFCCC) begin bad++; $display("FAIL single_table got=%h want=fccc", sif.table_out); end
        // Results must hold until the next accepted start.
        repeat (10) @(negedge clk);
        total++;
        if (sif.first_fail !== 4'd5 || sif.mismatch_count !== 5'd1) begin
            bad++; $display("FAIL single_hold got ff=%0d mm=%0d want 5 1", sif.first_fail, sif.mismatch_count);
        end
    endtask

    task automatic test_all_wrong;
        int de, np;
        func = 16'hFCCC;
        do_sweep(~16'hFCCC, -1, -1, de, np);
        total++;
        if (sif.mismatch_count !== 5'd16) begin bad++; $display("FAIL wrong_mm got=%0d want=16", sif.mismatch_count); end
        total++;
        if (sif.first_fail !== 4'd0 || sif.fail_valid !== 1'b1) begin
            bad++; $display("FAIL wrong_first got ff=%0d fv=%b want 0 1", sif.first_fail, sif.fail_valid);
        end
    endtask

    task automatic test_start_during_sweep;
        int de, np;
        func = 16'hFCCC;
        do_sweep(16'hFCCC, 6, 21, de, np);
        total++;
        if (de !== 33 || np !== 1) begin
            bad++; $display("FAIL busy_start got edge=%0d pulses=%0d want 33 1", de, np);
        end
        total++;
        if (sif.table_out !== 16'hFCCC || sif.mismatch_count !== 5'd0 || sif.fail_valid !== 1'b0) begin
            bad++; $display("FAIL busy_start_results got table=%h mm=%0d fv=%b want fccc 0 0",
                            sif.table_out, sif.mismatch_count, sif.fail_valid);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int n0, de, np;
        func = 16'hFCCC;
        n0 = done_pulses;
        @(negedge clk);
        sif.expected = ~16'hFCCC;
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (sif.busy !== 1'b0 || sif.x !== 4'd0) begin
            bad++; $display("FAIL midrst_ctrl got busy=%b x=%h want 0 0", sif.busy, sif.x);
        end
        total++;
        if (sif.table_out !== 16'd0 || sif.mismatch_count !== 5'd0) begin
            bad++; $display("FAIL midrst_results got table=%h mm=%0d want 0 0", sif.table_out, sif.mismatch_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (done_pulses - n0 !== 0) begin bad++; $display("FAIL midrst_done got=%0d want=0", done_pulses - n0); end
        do_sweep(16'hFCCC, -1, -1, de, np);
        total++;
        if (de !== 33 || sif.table_out !== 16'hFCCC || sif.mismatch_count !== 5'd0) begin
            bad++; $display("FAIL midrst_resweep got edge=%0d table=%h mm=%0d want 33 fccc 0",
                            de, sif.table_out, sif.mismatch_count);
        end
    endtask

    task automatic test_start_held;
        int edges, d1, d2;
        func = 16'hFCCC;
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        sif.expected = 16'hFCCC;
        sif.start = 1'b1;
        @(posedge clk);
        edges = 1;
        for (int c = 0; c < 200 && d2 < 0; c++) begin
            @(negedge clk);
            if (sif.done) begin
                if (d1 < 0) d1 = edges;
                else d2 = edges;
            end
            @(posedge clk);
            edges++;
        end
        @(negedge clk);
        sif.start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (d1 !== 33 || d2 !== 67) begin
            bad++; $display("FAIL held_start got d1=%0d d2=%0d want 33 67", d1, d2);
        end
        total++;
        if (sif.busy !== 1'b0) begin bad++; $display("FAIL held_idle got busy=%b want=0", sif.busy); end
    endtask

    task automatic test_random;
        int de, np;
        logic [15:0] e, flip;
        for (int it = 0; it < 8; it++) begin
            func = 16'($urandom);
            flip = (it % 4 == 0) ? 16'd0 : 16'($urandom & $urandom & $urandom);
            e = func ^ flip;
            do_sweep(e, -1, -1, de, np);
            total++;
            if (de !== 33 || np !== 1) begin
                bad++; $display("FAIL rand%0d_timing got edge=%0d pulses=%0d want 33 1", it, de, np);
            end
            total++;
            if (sif.table_out !== func) begin
                bad++; $display("FAIL rand%0d_table got=%h want=%h", it, sif.table_out, func);
            end
            total++;
            if (sif.mismatch_count !== 5'($countones(func ^ e)) || sif.fail_valid !== (flip != 16'd0)) begin
                bad++; $display("FAIL rand%0d_counts got mm=%0d fv=%b want %0d %b", it, sif.mismatch_count,
                                sif.fail_valid, $countones(func ^ e), flip != 16'd0);
            end
            total++;
            if (sif.first_fail !== model_first(func, e)) begin
                bad++; $display("FAIL rand%0d_first got=%h want=%h", it, sif.first_fail, model_first(func, e));
            end
        end
    endtask

    initial begin
        sif.start = 1'b0;
        sif.expected = 16'd0;
        test_reset();
        test_all_match();
        test_single_fault();
        test_all_wrong();
        test_start_during_sweep();
        test_reset_mid_sweep();
        test_start_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively drives every input combination of an N-input combinational function block.
- Samples the block's single output after a settle delay and builds the captured truth table.
- Compares the captured table against an expected minterm mask.
- Sits beside the combinational block in the lab designs and replaces hand-written vector lists with a start/done-controlled sweep.

Parameters:
- N_IN, 4, number of function inputs; the sweep covers 2^N_IN vectors.
- SETTLE, 1, cycles each vector is held before sampling; legal range >=1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begins a sweep; sampled only in IDLE
- expected  input  2^N_IN  expected output; bit k = value for input vector k
- x  output  N_IN  vector driven to the function block; x[N_IN-1] is the MSB (x1 of the block)
- f_in  input  1  function block output
- busy  output  1  high from the cycle after start through the last SAMPLE
- done  output  1  one-cycle pulse when the sweep completes
- table_out  output  2^N_IN  captured truth table; bit k = f_in sampled for vector k
- mismatch_count  output  N_IN+1  number of vectors where f_in != expected
- fail_valid  output  1  at least one mismatch in the last sweep
- first_fail  output  N_IN  vector value of the first mismatch, in application order

Behaviour:
- Reset (async, any state): FSM=IDLE; x=0, busy=0, done=0, table_out=0, mismatch_count=0, fail_valid=0, first_fail=0.
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - busy=0; x holds 0.
  - start=1 -> DRIVE; idx=0; wait counter=0.
  - The same edge clears table_out, mismatch_count, fail_valid and first_fail.
- DRIVE:
  - x = vec(idx); busy=1.
  - Held for exactly SETTLE cycles, then -> SAMPLE.
- SAMPLE (one cycle, x still = vec(idx)), on the exiting edge:
  - table_out[vec(idx)] <= f_in.
  - If f_in != expected[vec(idx)]: mismatch_count += 1.
  - If that is the first mismatch: fail_valid <= 1, first_fail <= vec(idx).
  - If idx == 2^N_IN-1 -> FINISH, else idx += 1 and -> DRIVE.
- FINISH:
  - done=1 for exactly one cycle; busy=0; x=0; -> IDLE.
- vec(idx) = idx in the default build.
- Latency:
  - Start sampled at edge E0.
  - done is high in the cycle after edge E0 + 2^N_IN*(SETTLE+1).
  - N_IN=4, SETTLE=1: done is high in the cycle starting 33 edges after start was sampled.
- Results (table_out, counts, first_fail) hold stable after done until the next accepted start.
- start while busy or in FINISH is ignored; no queuing.
- start held high continuously: a new sweep begins on the first IDLE cycle after FINISH.
- Reset mid-sweep: immediate abort, all outputs to reset values; no done pulse.
- Arithmetic:
  - idx is N_IN+1 bits internally so there is no wrap.
  - mismatch_count cannot overflow; max 2^N_IN fits in N_IN+1 bits.
- expected is sampled combinationally during each SAMPLE. It must be held stable by the user for the whole sweep; behaviour if it changes mid-sweep is per-vector and is not flagged.

Optional Feature:
- Macro: SWEEP_GRAY_EN.
- Defined:
  - vec(idx) = idx ^ (idx >> 1), so only one input toggles between consecutive vectors (glitch/hazard-friendly sweep).
  - table_out and expected remain indexed by actual vector value, not by idx.
  - first_fail reports the vector value.
- Undefined: binary order, vec(idx) = idx.
- Sweep latency is identical in both builds.

Test Plan:
- All match: N_IN=4, SETTLE=1. The bench models f = (x[3]&x[2]) | x[1], expected=16'hFCCC, start pulse. Required: table_out=16'hFCCC, mismatch_count=0, fail_valid=0, done pulses exactly 33 edges after start, busy low afterwards.
- Single fault: same model, expected=16'hFCEC. Required: mismatch_count=1, fail_valid=1, first_fail=4'd5, table_out=16'hFCCC.
- All wrong: expected=~16'hFCCC. Required: mismatch_count=5'd16, first_fail=0, fail_valid=1.
- Start during sweep: extra start pulses at cycles 5 and 20 after the first start. Required: a single done pulse at edge 33 and results identical to the all-match case.
- Reset mid-sweep: assert rst at cycle 10. Required: immediately busy=0, x=0, table_out=0, mismatch_count=0; no done pulse. A new start afterwards gives the all-match results.
- SWEEP_GRAY_EN build: monitor x each DRIVE. Required sequence 0,1,3,2,6,7,5,4,12,...,8, with Hamming distance 1 between consecutive vectors. Expected=16'hFCEC gives first_fail=4'd5 and mismatch_count=1.
